// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns
// for the ten decimal digits, the invalid-digit code and the FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Signal bundle between a scanned seven-segment display driver and the
// decoder that reconstructs the displayed BCD frame.
interface seg7_scan_decoder_if #(
  parameter int NDIG = 4
);

  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic [4*NDIG-1:0] bcd;
  logic              bcd_valid;
  logic              err;
  logic [NDIG-1:0]   err_digit;

  modport master (
    output an, seg,
    input  bcd, bcd_valid, err, err_digit
  );

  modport slave (
    input  an, seg,
    output bcd, bcd_valid, err, err_digit
  );

endinterface

// File: rtl/seg7_lut.sv
// Combinational segment-pattern to decimal digit lookup; anything that is
// not one of the ten digit shapes is flagged invalid.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        valid = 1'b0;
        digit = DIGIT_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the BCD value shown on a multiplexed seven-segment display by
// sampling each digit once it is stable, and publishes frames seen twice.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] bcd,
  output logic              bcd_valid,
  output logic              err,
  output logic [NDIG-1:0]   err_digit
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t            state_reg, state_next;
  logic [NDIG-1:0]   an_lat_reg, an_lat_next;
  logic [6:0]        seg_lat_reg, seg_lat_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              sample;

  logic [NDIG-1:0]   captured_reg, captured_next;
  logic [4*NDIG-1:0] slots_reg, slots_next;
  logic [4*NDIG-1:0] prev_reg;
  logic              prev_ok_reg;
  logic [NDIG-1:0]   bad_mask;
  logic              frame_full;

  logic              lut_valid;
  logic [3:0]        lut_digit;
  logic [3:0]        digit_dec;

  logic              an_onehot;
  logic              an_same;
  logic              seg_same;

  assign an_onehot = (an != '0) && ((an & (an - NDIG'(1))) == '0);
  assign an_same   = (an == an_lat_reg);
  assign seg_same  = (seg == seg_lat_reg);

  // The latched pattern equals the live input whenever a sample is taken.
  seg7_lut u_lut (
    .seg   (seg_lat_reg),
    .valid (lut_valid),
    .digit (lut_digit)
  );

  assign digit_dec = lut_valid ? lut_digit : DIGIT_INVALID;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_WAIT;
      an_lat_reg  <= '0;
      seg_lat_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      an_lat_reg  <= an_lat_next;
      seg_lat_reg <= seg_lat_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    an_lat_next  = an_lat_reg;
    seg_lat_next = seg_lat_reg;
    cnt_next     = cnt_reg;
    sample       = 1'b0;
    case (state_reg)
      ST_SETTLE: begin
        if (!an_same) begin
          if (an_onehot) begin
            an_lat_next  = an;
            seg_lat_next = seg;
            cnt_next     = '0;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (!seg_same) begin
          seg_lat_next = seg;
          cnt_next     = '0;
        end else if (cnt_reg == CNT_LAST) begin
          sample     = 1'b1;
          state_next = ST_HELD;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      // Segment changes are ignored here; only a new digit select matters.
      ST_HELD: begin
        if (!an_same) begin
          if (an_onehot) begin
            an_lat_next  = an;
            seg_lat_next = seg;
            cnt_next     = '0;
            state_next   = ST_SETTLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      default: begin
        if (an_onehot) begin
          an_lat_next  = an;
          seg_lat_next = seg;
          cnt_next     = '0;
          state_next   = ST_SETTLE;
        end
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_slot
      assign slots_next[4*gi +: 4] = (sample && an_lat_reg[gi]) ? digit_dec
                                                                : slots_reg[4*gi +: 4];
      assign bad_mask[gi] = (slots_reg[4*gi +: 4] == DIGIT_INVALID);
    end
  endgenerate

  // A sample landing in the evaluation cycle already belongs to the next frame.
  assign frame_full    = &captured_reg;
  assign captured_next = (frame_full ? '0 : captured_reg) | (sample ? an_lat_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_reg <= '0;
      slots_reg    <= '0;
      prev_reg     <= '0;
      prev_ok_reg  <= 1'b0;
      bcd          <= '0;
      bcd_valid    <= 1'b0;
      err          <= 1'b0;
      err_digit    <= '0;
    end else begin
      captured_reg <= captured_next;
      slots_reg    <= slots_next;
      bcd_valid    <= 1'b0;
      err          <= 1'b0;
      if (frame_full) begin
        if (bad_mask != '0) begin
          err         <= 1'b1;
          err_digit   <= bad_mask;
          prev_ok_reg <= 1'b0;
        end else begin
          if (prev_ok_reg && (slots_reg == prev_reg) && (slots_reg != bcd)) begin
            bcd       <= slots_reg;
            bcd_valid <= 1'b1;
          end
          prev_reg    <= slots_reg;
          prev_ok_reg <= 1'b1;
        end
      end
    end
  end

endmodule
